// File: rtl/pipo_arbiter.sv
// Two-requester round-robin arbiter that sequences a shared PIPO register.
// The winner's data is captured on the grant edge, then the register sees a
// one-cycle Load strobe, HOLD_CYCLES of Tx, and the winner gets a one-cycle Ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; sample Req and pick a winner
// LOAD  | Load strobe high for one cycle, captured data on ParalelInput
// XMIT  | Tx high for HOLD_CYCLES cycles, counted by holdCnt
// ACK   | Ack pulses to the granted requester; pointer updates on exit
module pipo_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Req,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic [1:0]       Grant,
  output logic [1:0]       Ack,
  output logic             Load,
  output logic             Tx,
  output logic [WIDTH-1:0] ParalelInput,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XMIT = 2'd2,
    ACK  = 2'd3
  } stateT;

  // Last XMIT cycle index; the counter starts at 0 on LOAD->XMIT.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  stateT      state;
  logic [3:0] holdCnt;
  // Index of the requester granted last; 1 after reset so requester 0 wins a tie.
  logic       lastGrant;
  logic       pickB;

  // Round-robin winner selection from the current request vector
  always_comb begin
    pickB = 1'b0;
    case (Req)
      2'b10:   pickB = 1'b1;
      2'b11:   pickB = ~lastGrant;
      default: pickB = 1'b0;
    endcase
  end

  // Transaction sequencer; outputs are registered alongside the state so
  // they always match the state being entered.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      Grant        <= '0;
      Ack          <= '0;
      Load         <= 1'b0;
      Tx           <= 1'b0;
      Busy         <= 1'b0;
      ParalelInput <= '0;
      holdCnt      <= '0;
      lastGrant    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Req != 2'b00) begin
            Grant        <= pickB ? 2'b10 : 2'b01;
            ParalelInput <= pickB ? DataB : DataA;
            Load         <= 1'b1;
            Busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          Load    <= 1'b0;
          Tx      <= 1'b1;
          holdCnt <= '0;
          state   <= XMIT;
        end
        XMIT: begin
          if (holdCnt == HOLD_LAST) begin
            Tx    <= 1'b0;
            Ack   <= Grant;
            state <= ACK;
          end else begin
            holdCnt <= holdCnt + 4'd1;
          end
        end
        ACK: begin
          Ack       <= '0;
          Grant     <= '0;
          Busy      <= 1'b0;
          lastGrant <= Grant[1];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_arbiter.sv
// Bench for pipo_arbiter: three instances (HOLD_CYCLES 2, 1, 15) share inputs.
// A transaction-level model predicts each output from the cycle offset
// since the grant edge.
module tb_pipo_arbiter;
  localparam int W = 4;

  logic         Clk   = 1'b0;
  logic         Reset = 1'b0;
  logic [1:0]   Req   = 2'b00;
  logic [W-1:0] DataA = '0;
  logic [W-1:0] DataB = '0;

  logic [1:0]   gr  [3];
  logic [1:0]   ak  [3];
  logic         ld  [3];
  logic         tx  [3];
  logic         bz  [3];
  logic [W-1:0] pin [3];

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int H = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    pipo_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .DataA(DataA), .DataB(DataB),
      .Grant(gr[g]), .Ack(ak[g]), .Load(ld[g]), .Tx(tx[g]),
      .ParalelInput(pin[g]), .Busy(bz[g]));
  end

  function automatic int hv(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // Reference model: one in-flight transaction per instance, described by
  // its start edge, winner and captured data.
  int           edgeNo = 0;
  logic         mAct  [3];
  int           mStart[3];
  logic         mWin  [3];
  logic         mLast [3];
  logic [W-1:0] mData [3];

  always @(posedge Clk) begin
    edgeNo = edgeNo + 1;
    for (int i = 0; i < 3; i++) begin
      if (!Reset) begin
        mAct[i]  = 1'b0;
        mLast[i] = 1'b1;
        mData[i] = '0;
      end else if (mAct[i]) begin
        if (edgeNo - mStart[i] == hv(i) + 2) begin
          mAct[i]  = 1'b0;
          mLast[i] = mWin[i];
        end
      end else if (Req != 2'b00) begin
        if (Req == 2'b01)      mWin[i] = 1'b0;
        else if (Req == 2'b10) mWin[i] = 1'b1;
        else                   mWin[i] = ~mLast[i];
        mData[i]  = mWin[i] ? DataB : DataA;
        mAct[i]   = 1'b1;
        mStart[i] = edgeNo;
      end
    end
  end

  function automatic logic [1:0] oneHot(logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  function automatic int offs(int i);
    return edgeNo - mStart[i];
  endfunction

  function automatic logic [1:0] eGrant(int i);
    return mAct[i] ? oneHot(mWin[i]) : 2'b00;
  endfunction

  function automatic logic [1:0] eAck(int i);
    return (mAct[i] && offs(i) == hv(i) + 1) ? oneHot(mWin[i]) : 2'b00;
  endfunction

  function automatic logic eLoad(int i);
    return mAct[i] && offs(i) == 0;
  endfunction

  function automatic logic eTx(int i);
    return mAct[i] && offs(i) >= 1 && offs(i) <= hv(i);
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    Req   = 2'b00;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({gr[i], ak[i], ld[i], tx[i], bz[i], pin[i]} !== '0) begin
        bad++;
        $display("FAIL reset[%0d] outputs got=%b want=0", i,
                 {gr[i], ak[i], ld[i], tx[i], bz[i], pin[i]});
      end
    end
    Reset = 1'b1;
  endtask

  task automatic test_single();
    int nLoad = 0, nAck = 0, nBusy = 0, loadAt = -1, ackAt = -1, overlap = 0;
    int nTx [3] = '{0, 0, 0};
    logic [W-1:0] loadPin = '0;
    logic [1:0]   ackVal  = '0;
    DataA = 4'b1010;
    DataB = 4'b0110;
    Req   = 2'b01;
    @(negedge Clk);
    Req = 2'b00;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (tx[i]) nTx[i]++;
        if (tx[i] && ld[i]) overlap++;
      end
      if (ld[0]) begin nLoad++; loadAt = c; loadPin = pin[0]; end
      if (ak[0] != 2'b00) begin nAck++; ackAt = c; ackVal = ak[0]; end
      if (bz[0]) nBusy++;
      @(negedge Clk);
    end
    total++;
    if (nLoad !== 1 || loadAt !== 0) begin
      bad++; $display("FAIL single_load count=%0d at=%0d want count=1 at=0", nLoad, loadAt);
    end
    total++;
    if (loadPin !== 4'b1010) begin
      bad++; $display("FAIL single_pin got=%b want=1010", loadPin);
    end
    total++;
    if (nTx[0] !== 2) begin
      bad++; $display("FAIL single_tx_h2 got=%0d want=2", nTx[0]);
    end
    total++;
    if (nTx[1] !== 1) begin
      bad++; $display("FAIL sweep_tx_h1 got=%0d want=1", nTx[1]);
    end
    total++;
    if (nTx[2] !== 15) begin
      bad++; $display("FAIL sweep_tx_h15 got=%0d want=15", nTx[2]);
    end
    total++;
    if (nAck !== 1 || ackAt !== 3 || ackVal !== 2'b01) begin
      bad++; $display("FAIL single_ack count=%0d at=%0d val=%b want 1/3/01", nAck, ackAt, ackVal);
    end
    total++;
    if (nBusy !== 4) begin
      bad++; $display("FAIL single_busy got=%0d want=4", nBusy);
    end
    total++;
    if (overlap !== 0) begin
      bad++; $display("FAIL load_tx_overlap got=%0d want=0", overlap);
    end
  endtask

  task automatic test_contention();
    int n = 0, modelErr = 0;
    int           at  [3] = '{-1, -1, -1};
    logic [1:0]   gv  [3] = '{2'b00, 2'b00, 2'b00};
    logic [W-1:0] pv  [3] = '{4'b0, 4'b0, 4'b0};
    int           wantAt [3] = '{0, 5, 10};
    logic [1:0]   wantG  [3] = '{2'b01, 2'b10, 2'b01};
    logic [W-1:0] wantP  [3] = '{4'b0011, 4'b1100, 4'b0011};
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    DataA = 4'b0011;
    DataB = 4'b1100;
    Req   = 2'b11;
    @(negedge Clk);
    for (int c = 0; c < 15; c++) begin
      if (ld[0] && n < 3) begin at[n] = c; gv[n] = gr[0]; pv[n] = pin[0]; n++; end
      for (int i = 0; i < 3; i++)
        if (gr[i] !== eGrant(i) || pin[i] !== mData[i]) modelErr++;
      @(negedge Clk);
    end
    Req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (at[k] !== wantAt[k] || gv[k] !== wantG[k] || pv[k] !== wantP[k]) begin
        bad++;
        $display("FAIL contention[%0d] at=%0d grant=%b pin=%b want at=%0d grant=%b pin=%b",
                 k, at[k], gv[k], pv[k], wantAt[k], wantG[k], wantP[k]);
      end
    end
    total++;
    if (modelErr !== 0) begin
      bad++; $display("FAIL contention_model errors=%0d want=0", modelErr);
    end
    repeat (20) @(negedge Clk);
  endtask

  task automatic test_data_stability();
    int drift = 0;
    DataA = 4'b1010;
    Req   = 2'b01;
    @(negedge Clk);
    Req = 2'b00;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) DataA = 4'b0101;
      if (pin[0] !== 4'b1010) drift++;
      @(negedge Clk);
    end
    total++;
    if (drift !== 0) begin
      bad++; $display("FAIL data_hold cycles_changed=%0d want=0 pin=%b", drift, pin[0]);
    end
    Req = 2'b01;
    @(negedge Clk);
    Req = 2'b00;
    total++;
    if (pin[0] !== 4'b0101 || ld[0] !== 1'b1) begin
      bad++; $display("FAIL data_regrant pin=%b load=%b want pin=0101 load=1", pin[0], ld[0]);
    end
    repeat (20) @(negedge Clk);
  endtask

  task automatic test_early_drop();
    int nAckB = 0, nOther = 0;
    logic [1:0] firstGrant;
    DataB = 4'($urandom_range(0, 15));
    Req   = 2'b10;
    @(negedge Clk);
    Req = 2'b00;
    firstGrant = gr[0];
    for (int c = 0; c < 10; c++) begin
      if (ak[0] === 2'b10) nAckB++;
      else if (ak[0] !== 2'b00) nOther++;
      @(negedge Clk);
    end
    total++;
    if (firstGrant !== 2'b10 || nAckB !== 1 || nOther !== 0) begin
      bad++;
      $display("FAIL early_drop grant=%b ack10=%0d other=%0d want grant=10 ack10=1 other=0",
               firstGrant, nAckB, nOther);
    end
    repeat (20) @(negedge Clk);
  endtask

  task automatic test_reset_mid_xmit();
    int stray = 0;
    DataA = 4'b1111;
    Req   = 2'b01;
    @(negedge Clk);
    Req = 2'b00;
    @(negedge Clk);
    total++;
    if (tx[0] !== 1'b1) begin
      bad++; $display("FAIL rst_xmit_pre tx=%b want=1", tx[0]);
    end
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({gr[i], ak[i], ld[i], tx[i], bz[i], pin[i]} !== '0) begin
        bad++;
        $display("FAIL rst_xmit_clear[%0d] got=%b want=0", i,
                 {gr[i], ak[i], ld[i], tx[i], bz[i], pin[i]});
      end
    end
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 3; i++) if (ak[i] !== 2'b00 || bz[i] !== 1'b0) stray++;
      @(negedge Clk);
    end
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL rst_xmit_no_ack stray=%0d want=0", stray);
    end
    DataA = 4'b0110;
    DataB = 4'b1001;
    Req   = 2'b11;
    @(negedge Clk);
    Req = 2'b00;
    total++;
    if (gr[0] !== 2'b01 || pin[0] !== 4'b0110) begin
      bad++; $display("FAIL rst_xmit_prio grant=%b pin=%b want grant=01 pin=0110", gr[0], pin[0]);
    end
    repeat (20) @(negedge Clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (gr[i] !== eGrant(i) || ak[i] !== eAck(i) || ld[i] !== eLoad(i) ||
            tx[i] !== eTx(i) || bz[i] !== mAct[i] || pin[i] !== mData[i]) begin
          bad++;
          $display("FAIL random[%0d] cyc=%0d got g=%b a=%b l=%b t=%b b=%b p=%b want g=%b a=%b l=%b t=%b b=%b p=%b",
                   i, c, gr[i], ak[i], ld[i], tx[i], bz[i], pin[i],
                   eGrant(i), eAck(i), eLoad(i), eTx(i), mAct[i], mData[i]);
        end
        total++;
        if ((ld[i] && tx[i]) || gr[i] === 2'b11) begin
          bad++;
          $display("FAIL random_invariant[%0d] cyc=%0d load=%b tx=%b grant=%b", i, c, ld[i], tx[i], gr[i]);
        end
      end
      Reset = ($urandom_range(0, 99) != 0);
      Req   = 2'($urandom_range(0, 3));
      DataA = 4'($urandom_range(0, 15));
      DataB = 4'($urandom_range(0, 15));
      @(negedge Clk);
    end
    Req = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mAct[i]   = 1'b0;
      mLast[i]  = 1'b1;
      mWin[i]   = 1'b0;
      mStart[i] = 0;
      mData[i]  = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_data_stability();
    test_early_drop();
    test_reset_mid_xmit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
